// File: rtl/modalu_pkg.sv
// Shared opcodes, FSM encoding and latency
// formula for the sequential modular ALU.
package modalu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_EXP = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARITH,
    S_MUL,
    S_EXP_SQ,
    S_EXP_MUL,
    S_DONE
  } state_t;

  // Cycles from accept edge to the edge
  // where out_valid rises.
  function automatic int unsigned op_latency(
    input int unsigned width,
    input logic [2:0]  op,
    input logic        err,
    input int unsigned ones
  );
    if (err) return 1;
    if (op == OP_MUL) return width + 1;
    if (op == OP_EXP)
      return 1 + (width + ones) * (width + 1);
    return 1;
  endfunction

endpackage

// File: rtl/modular_alu_seq_if.sv
// Request/response handshake bundle for
// the sequential modular ALU.
interface modular_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] M;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R;
  logic             err;

  modport master (
    output in_valid, op, A, B, M, out_ready,
    input  in_ready, out_valid, R, err
  );

  modport slave (
    input  in_valid, op, A, B, M, out_ready,
    output in_ready, out_valid, R, err
  );
endinterface

// File: rtl/mod_mul_seq.sv
// Interleaved shift-add modular multiplier:
// one load cycle then WIDTH step cycles.
module mod_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] xq;
  logic [WIDTH-1:0] yq;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_r;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;

  // One step: double, reduce, add, reduce.
  always_comb begin
    dbl   = {acc, 1'b0};
    dbl_r = dbl;
    if (dbl >= {1'b0, mq})
      dbl_r = dbl - {1'b0, mq};
    sum = dbl_r;
    if (yq[WIDTH-1])
      sum = dbl_r + {1'b0, xq};
    nxt = sum[WIDTH-1:0];
    if (sum >= {1'b0, mq})
      nxt = WIDTH'(sum - {1'b0, mq});
  end

  // Load on start, then walk y MSB-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      xq   <= '0;
      yq   <= '0;
      mq   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc  <= '0;
        xq   <= x;
        yq   <= y;
        mq   <= m;
        cnt  <= CW'(WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= nxt;
        yq  <= {yq[WIDTH-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = acc;

endmodule

// File: rtl/modular_alu_seq.sv
// Multi-cycle modular ALU coprocessor:
// add/sub/neg/mul/exp mod a runtime M.
module modular_alu_seq #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  modular_alu_seq_if.slave bus
);
  import modalu_pkg::*;

  localparam int IW = $clog2(WIDTH);

  state_t state;
  state_t state_n;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r_q;
  logic [IW-1:0]    idx;
  logic             bad_q;
  logic             kick;
  logic [WIDTH-1:0] res;
  logic             err_q;

  logic             accept;
  logic             bad_in;
  logic             b_chk;
  logic             mul_start;
  logic [WIDTH-1:0] mul_x;
  logic [WIDTH-1:0] mul_y;
  logic [WIDTH-1:0] mul_m;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  logic [WIDTH:0]   s1;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [WIDTH-1:0] neg_r;
  logic [WIDTH-1:0] ar_r;

  assign accept = (state == S_IDLE)
               && bus.in_valid;

  // Request legality, judged at accept.
  always_comb begin
    b_chk  = (bus.op == OP_ADD)
          || (bus.op == OP_SUB)
          || (bus.op == OP_MUL);
    bad_in = (bus.op > OP_NEG)
          || (bus.M == '0)
          || (bus.A >= bus.M)
          || (b_chk && (bus.B >= bus.M));
  end

  // Single-cycle add/sub/neg datapath.
  always_comb begin
    s1    = {1'b0, a_q} + {1'b0, b_q};
    add_r = s1[WIDTH-1:0];
    if (s1 >= {1'b0, m_q})
      add_r = WIDTH'(s1 - {1'b0, m_q});
    sub_r = a_q - b_q;
    if (a_q < b_q)
      sub_r = a_q - b_q + m_q;
    neg_r = '0;
    if (a_q != '0)
      neg_r = m_q - a_q;
    ar_r = neg_r;
    unique case (1'b1)
      (op_q == OP_ADD): ar_r = add_r;
      (op_q == OP_SUB): ar_r = sub_r;
      default:          ar_r = neg_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and multiplier launches.
  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    mul_x     = r_q;
    mul_y     = r_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_in) begin
            state_n = S_ARITH;
          end else if (bus.op == OP_MUL) begin
            state_n   = S_MUL;
            mul_start = 1'b1;
            mul_x     = bus.A;
            mul_y     = bus.B;
          end else if (bus.op == OP_EXP) begin
            state_n = S_EXP_SQ;
          end else begin
            state_n = S_ARITH;
          end
        end
      end
      S_ARITH: state_n = S_DONE;
      S_MUL: begin
        if (mul_done) state_n = S_DONE;
      end
      S_EXP_SQ: begin
        if (kick && !mul_busy) begin
          mul_start = 1'b1;
        end else if (mul_done) begin
          if (b_q[idx]) begin
            state_n   = S_EXP_MUL;
            mul_start = 1'b1;
            mul_x     = mul_p;
            mul_y     = a_q;
          end else if (idx == '0) begin
            state_n = S_DONE;
          end else begin
            mul_start = 1'b1;
            mul_x     = mul_p;
            mul_y     = mul_p;
          end
        end
      end
      S_EXP_MUL: begin
        if (mul_done) begin
          if (idx == '0) begin
            state_n = S_DONE;
          end else begin
            state_n   = S_EXP_SQ;
            mul_start = 1'b1;
            mul_x     = mul_p;
            mul_y     = mul_p;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign mul_m = (state == S_IDLE)
               ? bus.M : m_q;

  // Operand capture, bit walk and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      r_q   <= '0;
      idx   <= '0;
      bad_q <= 1'b0;
      kick  <= 1'b0;
      res   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        a_q   <= bus.A;
        b_q   <= bus.B;
        m_q   <= bus.M;
        bad_q <= bad_in;
        kick  <= !bad_in
              && (bus.op == OP_EXP);
        idx   <= IW'(WIDTH - 1);
        r_q   <= (bus.M == WIDTH'(1))
               ? '0 : WIDTH'(1);
      end
      if (state == S_EXP_SQ && kick)
        kick <= 1'b0;
      if (state == S_ARITH) begin
        res   <= bad_q ? '0 : ar_r;
        err_q <= bad_q;
      end
      if (state == S_MUL && mul_done) begin
        res   <= mul_p;
        err_q <= 1'b0;
      end
      if (state == S_EXP_SQ && !kick
          && mul_done && !b_q[idx]) begin
        if (idx == '0) begin
          res   <= mul_p;
          err_q <= 1'b0;
        end else begin
          idx <= idx - IW'(1);
        end
      end
      if (state == S_EXP_MUL && mul_done) begin
        if (idx == '0) begin
          res   <= mul_p;
          err_q <= 1'b0;
        end else begin
          idx <= idx - IW'(1);
        end
      end
    end
  end

  mod_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .x     (mul_x),
    .y     (mul_y),
    .m     (mul_m),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.R         = res;
  assign bus.err       = err_q;

endmodule
